// File: rtl/mul_pkg.sv
// Shared types for the multiply issue unit: operation codes, FSM states
// and small helpers describing how each operation treats its operands.
package mul_pkg;

    // Operation encoding as it arrives on iOp.
    typedef enum logic [1:0] {
        MUL    = 2'b00,
        MULH   = 2'b01,
        MULHSU = 2'b10,
        MULHU  = 2'b11
    } mul_op_e;

    // Issue FSM states; at most one operation is in flight.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WAIT  = 3'd2,
        DONE  = 3'd3,
        DRAIN = 3'd4
    } mul_issue_state_e;

    // Source 1 is treated as signed for MULH and MULHSU.
    function automatic logic src1Signed(mul_op_e op);
        return (op == MULH) || (op == MULHSU);
    endfunction

    // Source 2 is treated as signed only for MULH.
    function automatic logic src2Signed(mul_op_e op);
        return (op == MULH);
    endfunction

    // Every operation except MUL returns the upper half of the product.
    function automatic logic selectsHigh(mul_op_e op);
        return (op != MUL);
    endfunction

endpackage

// File: rtl/mul_issue_unit_if.sv
// Bundle of the request, multiplier issue, multiplier result and writeback
// handshakes of the multiply issue unit.
//
// Handshake rule for every valid/ready pair below: a transfer happens on a
// rising clock edge where valid and ready are both 1; once valid is raised
// the payload stays stable and valid stays high until that transfer.
interface mul_issue_unit_if #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4
);
    // Upstream request
    logic             iValid;
    logic             oReady;
    logic [1:0]       iOp;
    logic [WIDTH-1:0] iSrc1;
    logic [WIDTH-1:0] iSrc2;
    logic [TAG_W-1:0] iTag;
    logic             iFlush;

    // Multiplier issue
    logic             oMulValid;
    logic             iMulReady;
    logic [WIDTH:0]   oMulc;
    logic [WIDTH:0]   oMulr;

    // Multiplier result
    logic             iMulRsltValid;
    logic             oMulRsltReady;
    logic [WIDTH-1:0] iRsltHi;
    logic [WIDTH-1:0] iRsltLo;

    // Downstream writeback
    logic             oValid;
    logic             iReady;
    logic [WIDTH-1:0] oRslt;
    logic [TAG_W-1:0] oTag;

    // View of the issue unit itself.
    modport slave (
        input  iValid, iOp, iSrc1, iSrc2, iTag, iFlush,
        input  iMulReady, iMulRsltValid, iRsltHi, iRsltLo, iReady,
        output oReady, oMulValid, oMulc, oMulr, oMulRsltReady,
        output oValid, oRslt, oTag
    );

    // View of the surrounding pipeline and multiplier.
    modport master (
        output iValid, iOp, iSrc1, iSrc2, iTag, iFlush,
        output iMulReady, iMulRsltValid, iRsltHi, iRsltLo, iReady,
        input  oReady, oMulValid, oMulc, oMulr, oMulRsltReady,
        input  oValid, oRslt, oTag
    );

endinterface

// File: rtl/mul_operand_ext.sv
// Combinational operand extension: widens both sources by one bit so a
// single signed (WIDTH+1)x(WIDTH+1) multiplier covers all four operations.
module mul_operand_ext
    import mul_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  mul_op_e          op,
    input  logic [WIDTH-1:0] src1,
    input  logic [WIDTH-1:0] src2,
    output logic [WIDTH:0]   mulc,
    output logic [WIDTH:0]   mulr
);

    // Sign-extend only where the operation treats the source as signed.
    assign mulc = {src1Signed(op) & src1[WIDTH-1], src1};
    assign mulr = {src2Signed(op) & src2[WIDTH-1], src2};

endmodule

// File: rtl/mul_issue_unit.sv
// Multiply issue unit: accepts one request, issues extended operands to an
// external multiplier, collects the result and hands it downstream with
// its tag. A flush kills the held operation; any multiplier result still
// owed is drained and dropped.
//
// Optional feature: define MUL_ZERO_SKIP_EN to bypass the multiplier when
// either source is zero (result 0, valid one cycle after acceptance).
module mul_issue_unit
    import mul_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             nRst,
    mul_issue_unit_if.slave  bus,
    output mul_issue_state_e dbgState
);

    mul_issue_state_e state;
    mul_op_e          opReg;
    logic [TAG_W-1:0] tagReg;
    logic [WIDTH:0]   mulcReg;
    logic [WIDTH:0]   mulrReg;
    logic [WIDTH-1:0] rsltReg;
    logic             mulValidReg;
    logic             rsltReadyReg;
    logic             validReg;
    logic             flushPend;

    mul_op_e          reqOp;
    logic [WIDTH:0]   extMulc;
    logic [WIDTH:0]   extMulr;
    logic             skipMul;
    logic             xfer;

    assign reqOp = mul_op_e'(bus.iOp);

    mul_operand_ext #(
        .WIDTH (WIDTH)
    ) uOperandExt (
        .op   (reqOp),
        .src1 (bus.iSrc1),
        .src2 (bus.iSrc2),
        .mulc (extMulc),
        .mulr (extMulr)
    );

`ifdef MUL_ZERO_SKIP_EN
    // A zero operand makes the product zero regardless of the operation.
    assign skipMul = (bus.iSrc1 == '0) || (bus.iSrc2 == '0);
`else
    assign skipMul = 1'b0;
`endif

    // A flush in IDLE holds off acceptance for that cycle.
    assign bus.oReady = (state == IDLE) && !bus.iFlush;
    assign xfer       = bus.iValid && bus.oReady;

    assign bus.oMulValid     = mulValidReg;
    assign bus.oMulc         = mulcReg;
    assign bus.oMulr         = mulrReg;
    assign bus.oMulRsltReady = rsltReadyReg;
    assign bus.oValid        = validReg;
    assign bus.oRslt         = rsltReg;
    assign bus.oTag          = tagReg;
    assign dbgState          = state;

    // Issue FSM with registered handshake outputs and payload.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state        <= IDLE;
            opReg        <= MUL;
            tagReg       <= '0;
            mulcReg      <= '0;
            mulrReg      <= '0;
            rsltReg      <= '0;
            mulValidReg  <= 1'b0;
            rsltReadyReg <= 1'b0;
            validReg     <= 1'b0;
            flushPend    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (xfer) begin
                        opReg   <= reqOp;
                        tagReg  <= bus.iTag;
                        mulcReg <= extMulc;
                        mulrReg <= extMulr;
                        if (skipMul) begin
                            rsltReg  <= '0;
                            validReg <= 1'b1;
                            state    <= DONE;
                        end else begin
                            mulValidReg <= 1'b1;
                            state       <= ISSUE;
                        end
                    end
                end

                ISSUE: begin
                    // The issue handshake always completes; a flush seen
                    // while stalled is remembered and routes us to DRAIN.
                    if (bus.iMulReady) begin
                        mulValidReg  <= 1'b0;
                        rsltReadyReg <= 1'b1;
                        flushPend    <= 1'b0;
                        state        <= (bus.iFlush || flushPend) ? DRAIN : WAIT;
                    end else if (bus.iFlush) begin
                        flushPend <= 1'b1;
                    end
                end

                WAIT: begin
                    if (bus.iMulRsltValid) begin
                        rsltReadyReg <= 1'b0;
                        if (bus.iFlush) begin
                            state <= IDLE;
                        end else begin
                            rsltReg  <= selectsHigh(opReg) ? bus.iRsltHi : bus.iRsltLo;
                            validReg <= 1'b1;
                            state    <= DONE;
                        end
                    end else if (bus.iFlush) begin
                        state <= DRAIN;
                    end
                end

                DRAIN: begin
                    // Swallow the owed result without reporting it.
                    if (bus.iMulRsltValid) begin
                        rsltReadyReg <= 1'b0;
                        state        <= IDLE;
                    end
                end

                DONE: begin
                    // Flush and accept both retire the result exactly once.
                    if (bus.iReady || bus.iFlush) begin
                        validReg <= 1'b0;
                        state    <= IDLE;
                    end
                end

                default: begin
                    mulValidReg  <= 1'b0;
                    rsltReadyReg <= 1'b0;
                    validReg     <= 1'b0;
                    flushPend    <= 1'b0;
                    state        <= IDLE;
                end
            endcase
        end
    end

endmodule
